// File: rtl/rv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the rv_cpu data-memory bus.
// Byte FIFO feeds a baud serializer; status and divider are readable with 1-cycle latency.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for one bit period
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high); chains straight into next frame
module rv_uart_tx #(
    parameter logic [31:0] g_base_addr = 32'h0010_0000,
    parameter int          g_clk_div   = 16,
    parameter int          g_fifo_log2 = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_write_i,
    output logic [31:0] dm_data_l_o,
    output logic        txd_o,
    output logic        tx_busy_o
);

    localparam int DEPTH = 2 ** g_fifo_log2;
    localparam int CW    = g_fifo_log2 + 1;
    localparam logic [CW-1:0]          CNT_ONE = CW'(1);
    localparam logic [CW-1:0]          CNT_FULL = CW'(DEPTH);
    localparam logic [g_fifo_log2-1:0] PTR_ONE = g_fifo_log2'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state;
    logic [7:0]             shifter;
    logic [2:0]             bit_idx;
    logic [15:0]            timer;
    logic [15:0]            bit_limit;

    logic [7:0]             mem [DEPTH];
    logic [g_fifo_log2-1:0] wr_ptr;
    logic [g_fifo_log2-1:0] rd_ptr;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic [15:0]            div_reg;

    logic        hit;
    logic [1:0]  word;
    logic        empty;
    logic        full;
    logic        bit_end;
    logic        pop;
    logic        wr_txdata;
    logic        push_ok;
    logic        clr_ovf;
    logic        wr_div;
    logic [15:0] eff_div;
    logic [7:0]  count_byte;
    logic [31:0] status_word;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign hit        = dm_addr_i[31:4] == g_base_addr[31:4];
    assign word       = dm_addr_i[3:2];
    assign empty      = count == '0;
    assign full       = count == CNT_FULL;
    assign bit_end    = timer == 16'd0;
    assign pop        = !empty && (state == S_IDLE || (state == S_STOP && bit_end));
    assign wr_txdata  = dm_write_i && hit && word == 2'd0 && dm_data_select_i[0];
    assign push_ok    = wr_txdata && (!full || pop);
    assign clr_ovf    = dm_write_i && hit && word == 2'd1 && dm_data_select_i[0] && dm_data_s_i[3];
    assign wr_div     = dm_write_i && hit && word == 2'd2 && dm_data_select_i[1:0] == 2'b11;
    assign eff_div    = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign count_byte = 8'(count);
    assign status_word = {16'h0, count_byte, 4'h0, overflow, state == S_IDLE, empty, full};
    assign unused_bits = ^{dm_data_s_i[31:16], dm_data_select_i[3:2], dm_addr_i[1:0]};

    always_comb begin
        rd_word = 32'h0;
        if (hit) begin
            case (word)
                2'd1:    rd_word = status_word;
                2'd2:    rd_word = {16'h0, div_reg};
                default: rd_word = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= dm_data_s_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            div_reg     <= 16'(g_clk_div);
            dm_data_l_o <= 32'h0;
        end else begin
            dm_data_l_o <= rd_word;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A rejected push in the same cycle as a clear leaves the flag set.
            if (wr_txdata && !push_ok) overflow <= 1'b1;
            else if (clr_ovf)          overflow <= 1'b0;
            if (wr_div) div_reg <= dm_data_s_i[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            shifter   <= 8'h0;
            bit_idx   <= 3'd0;
            timer     <= 16'd0;
            bit_limit <= 16'd1;
            txd_o     <= 1'b1;
            tx_busy_o <= 1'b0;
        end else begin
            // Line level follows the state one cycle later, so a write shows on txd two edges on.
            case (state)
                S_START: txd_o <= 1'b0;
                S_DATA:  txd_o <= shifter[0];
                default: txd_o <= 1'b1;
            endcase
            tx_busy_o <= (state != S_IDLE) || !empty;

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shifter   <= mem[rd_ptr];
                        bit_limit <= eff_div;
                        timer     <= eff_div - 16'd1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        timer   <= bit_limit - 16'd1;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer   <= bit_limit - 16'd1;
                        shifter <= shifter >> 1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            shifter   <= mem[rd_ptr];
                            bit_limit <= eff_div;
                            timer     <= eff_div - 16'd1;
                            state     <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_uart_tx.sv
// Directed self-checking bench for rv_uart_tx: register map, frame timing,
// back-to-back frames, overflow, divider edge cases and mid-frame reset.
module tb_rv_uart_tx;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_write_i;
    logic [31:0] dm_data_l_o;
    logic        txd_o;
    logic        tx_busy_o;

    int checks = 0;
    int errors = 0;

    rv_uart_tx dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_write_i       (dm_write_i),
        .dm_data_l_o      (dm_data_l_o),
        .txd_o            (txd_o),
        .tx_busy_o        (tx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        dm_addr_i        = addr;
        dm_data_s_i      = data;
        dm_data_select_i = sel;
        dm_write_i       = 1'b1;
        tick();
        dm_write_i       = 1'b0;
        dm_addr_i        = 32'h0;
        dm_data_s_i      = 32'h0;
        dm_data_select_i = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        dm_addr_i  = addr;
        dm_write_i = 1'b0;
        tick();
        data       = dm_data_l_o;
        dm_addr_i  = 32'h0;
    endtask

    // Call when txd should be showing the first start-bit clock.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic e;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[k-1];
            for (int c = 0; c < div; c++) begin
                check(tag, {31'h0, txd_o}, {31'h0, e});
                tick();
            end
        end
    endtask

    logic [31:0] rd;

    initial begin
        rst_i            = 1'b1;
        dm_addr_i        = 32'h0;
        dm_data_s_i      = 32'h0;
        dm_data_select_i = 4'h0;
        dm_write_i       = 1'b0;
        #22;
        check("rst_txd",   {31'h0, txd_o},     32'h1);
        check("rst_busy",  {31'h0, tx_busy_o}, 32'h0);
        check("rst_rdata", dm_data_l_o,        32'h0);
        rst_i = 1'b0;
        tick();

        bus_read(BASE + 32'h4, rd); check("status_reset", rd, 32'h0000_0006);
        check("rdata_miss", dm_data_l_o, 32'h0000_0006);
        tick();                     check("rdata_nohit", dm_data_l_o, 32'h0);
        bus_read(BASE + 32'hC, rd); check("read_rsvd",  rd, 32'h0);
        bus_read(BASE,         rd); check("read_txdata", rd, 32'h0);
        bus_read(BASE + 32'h8, rd); check("div_reset",  rd, 32'h0000_0010);

        bus_write(BASE, 32'h77, 4'b1110);
        bus_read(BASE + 32'h4, rd); check("no_lane0_push", rd, 32'h0000_0006);
        bus_write(BASE + 32'h8, 32'h4, 4'b0011);
        bus_write(BASE + 32'h8, 32'h9, 4'b0001);
        bus_read(BASE + 32'h8, rd); check("div_write", rd, 32'h0000_0004);

        // Single frame 0x55 at 4 clocks/bit
        bus_write(BASE, 32'h55, 4'b0001);
        check("lat_n_txd",  {31'h0, txd_o},     32'h1);
        check("lat_n_busy", {31'h0, tx_busy_o}, 32'h0);
        tick();
        check("lat_n1_txd",  {31'h0, txd_o},     32'h1);
        check("lat_n1_busy", {31'h0, tx_busy_o}, 32'h1);
        tick();
        check_frame(8'h55, 4, "frame_55");
        check("post55_busy", {31'h0, tx_busy_o}, 32'h0);
        check("post55_txd",  {31'h0, txd_o},     32'h1);

        // Two contiguous frames
        bus_write(BASE, 32'h41, 4'b0001);
        bus_write(BASE, 32'h42, 4'b0001);
        tick();
        check_frame(8'h41, 4, "frame_41");
        check_frame(8'h42, 4, "frame_42");
        check("post42_busy", {31'h0, tx_busy_o}, 32'h0);

        // DIV=0 runs at 1 clock/bit; DIV=8 written mid-frame applies to the next frame
        bus_write(BASE + 32'h8, 32'h0, 4'b0011);
        bus_write(BASE, 32'hFF, 4'b0001);
        bus_write(BASE, 32'h00, 4'b0001);
        bus_write(BASE + 32'h8, 32'h8, 4'b0011);
        check_frame(8'hFF, 1, "frame_ff_div0");
        check_frame(8'h00, 8, "frame_00_div8");
        bus_read(BASE + 32'h8, rd); check("div8_read", rd, 32'h0000_0008);

        // Reset in the middle of data bit 3 of 0xA5 (bit3 = 0)
        bus_write(BASE, 32'hA5, 4'b0001);
        bus_write(BASE, 32'h33, 4'b0001);
        repeat (35) tick();
        check("mid_bit3_txd",  {31'h0, txd_o},     32'h0);
        check("mid_bit3_busy", {31'h0, tx_busy_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_txd",  {31'h0, txd_o},     32'h1);
        check("async_rst_busy", {31'h0, tx_busy_o}, 32'h0);
        #10;
        rst_i = 1'b0;
        tick();
        tick();
        check("post_rst_txd",  {31'h0, txd_o},     32'h1);
        check("post_rst_busy", {31'h0, tx_busy_o}, 32'h0);
        bus_read(BASE + 32'h4, rd); check("post_rst_status", rd, 32'h0000_0006);
        bus_read(BASE + 32'h8, rd); check("post_rst_div",    rd, 32'h0000_0010);

        // Overflow: one byte goes to the shifter, eight fill the FIFO, the tenth is dropped
        bus_write(BASE + 32'h8, 32'd100, 4'b0011);
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + i, 4'b0001);
        bus_read(BASE + 32'h4, rd); check("ovf_status", rd, 32'h0000_0809);
        bus_write(BASE + 32'h4, 32'h4, 4'b0001);
        bus_read(BASE + 32'h4, rd); check("ovf_keep", rd, 32'h0000_0809);
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);
        bus_read(BASE + 32'h4, rd); check("ovf_clear", rd, 32'h0000_0801);
        check("ovf_busy", {31'h0, tx_busy_o}, 32'h1);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        bus_read(BASE + 32'h4, rd); check("final_status", rd, 32'h0000_0006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
